// File: rtl/audio_frame_router_if.sv
// Frame-mover bus bundle: ADC FIFO read side, effects chain handshake and DAC FIFO write side.
interface audio_frame_router_if #(
  parameter int unsigned CH_W   = 16,
  parameter int unsigned NUM_CH = 2
);
  localparam int unsigned FRAME_W = NUM_CH * CH_W;

  logic               adc_empty;
  logic               adc_rd;
  logic [FRAME_W-1:0] adc_rdata;
  logic               fx_tx_valid;
  logic               fx_tx_ready;
  logic [FRAME_W-1:0] fx_tx_data;
  logic               fx_rx_valid;
  logic [FRAME_W-1:0] fx_rx_data;
  logic               dac_full;
  logic               dac_wr;
  logic [FRAME_W-1:0] dac_wdata;

  modport master (
    input  adc_empty, adc_rdata, fx_tx_ready, fx_rx_valid, fx_rx_data, dac_full,
    output adc_rd, fx_tx_valid, fx_tx_data, dac_wr, dac_wdata
  );

  modport slave (
    output adc_empty, adc_rdata, fx_tx_ready, fx_rx_valid, fx_rx_data, dac_full,
    input  adc_rd, fx_tx_valid, fx_tx_data, dac_wr, dac_wdata
  );
endinterface

// File: rtl/audio_frame_router.sv
// Moves one audio frame at a time from the ADC FIFO to the DAC FIFO, with bypass,
// effects-chain, mute and test-tone modes, effects timeout and per-channel peak metering.
module audio_frame_router #(
  parameter int unsigned CH_W       = 16,
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned FX_TIMEOUT = 1024,
  parameter int unsigned PEAK_WIN   = 4096,
  parameter int unsigned TONE_STEP  = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               mode,
  input  logic                     err_clr,
  audio_frame_router_if.master     bus,
  output logic [NUM_CH*CH_W-1:0]   peak,
  output logic                     peak_valid,
  output logic                     fx_timeout,
  output logic                     busy
);
  localparam int unsigned FRAME_W = NUM_CH * CH_W;
  localparam int unsigned TO_W    = $clog2(FX_TIMEOUT) + 1;
  localparam int unsigned WIN_W   = $clog2(PEAK_WIN) + 1;
  localparam logic [1:0]  MODE_FX   = 2'd1;
  localparam logic [1:0]  MODE_MUTE = 2'd2;
  localparam logic [1:0]  MODE_TONE = 2'd3;

  typedef enum logic [2:0] {IDLE, READ, LATCH, SEND_FX, WAIT_FX, WRITE} state_e;

  state_e             state_q, state_d;
  logic [1:0]         mode_r;
  logic [FRAME_W-1:0] frame_r, frame_d, wdata_d, dac_wdata_q;
  logic [CH_W-1:0]    phase_r;
  logic [TO_W-1:0]    to_cnt;
  logic [WIN_W-1:0]   win_cnt;
  logic [CH_W-1:0]    acc   [NUM_CH];
  logic [CH_W-1:0]    abs_c [NUM_CH];
  logic [CH_W-1:0]    max_c [NUM_CH];
  logic               adc_rd_q, fx_tx_valid_q, dac_wr_c;
  logic               to_hit_c, win_last_c, enter_write_c;

  // |x| of a signed sample; the most negative value saturates to the largest positive one
  function automatic logic [CH_W-1:0] sat_abs(input logic [CH_W-1:0] s);
    if (!s[CH_W-1])
      return s;
    if (s == {1'b1, {(CH_W-1){1'b0}}})
      return {1'b0, {(CH_W-1){1'b1}}};
    return ~s + CH_W'(1);
  endfunction

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      abs_c[k] = sat_abs(bus.adc_rdata[k*CH_W +: CH_W]);
      max_c[k] = (abs_c[k] > acc[k]) ? abs_c[k] : acc[k];
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Next-state, next-frame and DAC strobe; the write strobe follows dac_full combinationally
  always_comb begin
    state_d    = state_q;
    frame_d    = frame_r;
    dac_wr_c   = 1'b0;
    to_hit_c   = (to_cnt == TO_W'(FX_TIMEOUT - 1));
    win_last_c = (win_cnt == WIN_W'(PEAK_WIN - 1));
    case (state_q)
      IDLE:    if (!bus.adc_empty) state_d = READ;
      READ:    state_d = LATCH;
      LATCH: begin
        frame_d = bus.adc_rdata;
        state_d = (mode_r == MODE_FX) ? SEND_FX : WRITE;
      end
      SEND_FX: if (bus.fx_tx_ready) state_d = WAIT_FX;
      WAIT_FX: begin
        if (bus.fx_rx_valid) begin
          frame_d = bus.fx_rx_data;
          state_d = WRITE;
        end else if (to_hit_c) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (!bus.dac_full && !reset) begin
          dac_wr_c = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    enter_write_c = (state_d == WRITE) && (state_q != WRITE);
    case (mode_r)
      MODE_MUTE: wdata_d = '0;
      MODE_TONE: wdata_d = {NUM_CH{phase_r}};
      default:   wdata_d = frame_d;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      adc_rd_q      <= 1'b0;
      fx_tx_valid_q <= 1'b0;
      busy          <= 1'b0;
      mode_r        <= '0;
      frame_r       <= '0;
      dac_wdata_q   <= '0;
      phase_r       <= '0;
      to_cnt        <= '0;
      win_cnt       <= '0;
      peak          <= '0;
      peak_valid    <= 1'b0;
      fx_timeout    <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) acc[k] <= '0;
    end else begin
      adc_rd_q      <= (state_d == READ);
      fx_tx_valid_q <= (state_d == SEND_FX);
      busy          <= (state_d != IDLE);
      frame_r       <= frame_d;
      peak_valid    <= 1'b0;
      to_cnt        <= (state_q == WAIT_FX) ? to_cnt + TO_W'(1) : '0;
      if (state_q == IDLE && !bus.adc_empty)
        mode_r <= mode;
      if (enter_write_c) begin
        dac_wdata_q <= wdata_d;
        if (mode_r == MODE_TONE)
          phase_r <= phase_r + CH_W'(TONE_STEP);
      end
      // A timeout in the same cycle as err_clr leaves the flag set
      if (state_q == WAIT_FX && !bus.fx_rx_valid && to_hit_c)
        fx_timeout <= 1'b1;
      else if (err_clr)
        fx_timeout <= 1'b0;
      if (state_q == LATCH) begin
        if (win_last_c) begin
          win_cnt    <= '0;
          peak_valid <= 1'b1;
          for (int k = 0; k < NUM_CH; k++) begin
            peak[k*CH_W +: CH_W] <= max_c[k];
            acc[k]               <= '0;
          end
        end else begin
          win_cnt <= win_cnt + WIN_W'(1);
          for (int k = 0; k < NUM_CH; k++) acc[k] <= max_c[k];
        end
      end
    end
  end

  assign bus.adc_rd      = adc_rd_q;
  assign bus.fx_tx_valid = fx_tx_valid_q;
  assign bus.fx_tx_data  = frame_r;
  assign bus.dac_wr      = dac_wr_c;
  assign bus.dac_wdata   = dac_wdata_q;
endmodule

// File: tb/tb_audio_frame_router.sv
// Directed bench for audio_frame_router: expected DAC frames are queued when a frame is
// offered and compared against writes captured by the DAC-side monitor.
module tb_audio_frame_router;
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  mode;
  logic        err_clr;
  logic [31:0] peak;
  logic        peak_valid, fx_timeout, busy;

  audio_frame_router_if #(.CH_W(16), .NUM_CH(2)) bus ();

  audio_frame_router #(
    .CH_W(16), .NUM_CH(2), .FX_TIMEOUT(16), .PEAK_WIN(4), .TONE_STEP(64)
  ) dut (
    .clk(clk), .reset(reset), .mode(mode), .err_clr(err_clr), .bus(bus),
    .peak(peak), .peak_valid(peak_valid), .fx_timeout(fx_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  int          wr_cnt = 0, rd_cnt = 0, pv_cnt = 0;
  logic [31:0] obs_q[$];
  int          cyc_q[$];
  int          obs_rd = 0;
  logic [31:0] exp_q[$];
  int          checks = 0, errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.dac_wr) begin
      obs_q.push_back(bus.dac_wdata);
      cyc_q.push_back(cyc);
      wr_cnt <= wr_cnt + 1;
    end
    if (bus.adc_rd) rd_cnt <= rd_cnt + 1;
    if (peak_valid) pv_cnt <= pv_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic start_frame(input string tag, input logic [31:0] data, output int t0);
    int n;
    bus.adc_rdata = data;
    bus.adc_empty = 1'b0;
    t0 = cyc;
    n = 0;
    step();
    while (!bus.adc_rd && n < 10) begin step(); n++; end
    check({tag, "_adc_rd"}, 32'(bus.adc_rd), 32'd1);
    bus.adc_empty = 1'b1;
  endtask

  task automatic wait_write(input string tag, output int wcyc);
    int n;
    logic [31:0] exp_v;
    n = 0;
    wcyc = -1;
    while (obs_q.size() <= obs_rd && n < 40) begin step(); n++; end
    if (obs_q.size() <= obs_rd) begin
      check({tag, "_no_write"}, 32'(obs_q.size() - obs_rd), 32'd1);
    end else if (exp_q.size() == 0) begin
      check({tag, "_unexpected_write"}, 32'(exp_q.size()), 32'd1);
      obs_rd++;
    end else begin
      exp_v = exp_q.pop_front();
      check(tag, obs_q[obs_rd], exp_v);
      wcyc = cyc_q[obs_rd];
      obs_rd++;
    end
  endtask

  task automatic run_frame(input string tag, input logic [31:0] data, input logic [31:0] exp_v);
    int t0, wc;
    exp_q.push_back(exp_v);
    start_frame(tag, data, t0);
    wait_write(tag, wc);
  endtask

  task automatic wait_tx(input string tag, output int s);
    int n;
    n = 0;
    while (!bus.fx_tx_valid && n < 10) begin step(); n++; end
    check({tag, "_tx_valid"}, 32'(bus.fx_tx_valid), 32'd1);
    s = cyc;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    step();
  endtask

  initial begin
    int t0, wc, w0, r0, p0, s;
    reset = 1'b1; mode = 2'd0; err_clr = 1'b0;
    bus.adc_empty = 1'b1; bus.adc_rdata = '0;
    bus.fx_tx_ready = 1'b0; bus.fx_rx_valid = 1'b0; bus.fx_rx_data = '0;
    bus.dac_full = 1'b0;
    do_reset();

    // Reset state
    check("rst_adc_rd", 32'(bus.adc_rd), 32'd0);
    check("rst_dac_wr", 32'(bus.dac_wr), 32'd0);
    check("rst_fx_tx_valid", 32'(bus.fx_tx_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_flags", {29'd0, fx_timeout, peak_valid, 1'b0}, 32'd0);
    check("rst_peak", peak, 32'd0);
    check("rst_dac_wdata", bus.dac_wdata, 32'd0);

    // T1 bypass, latency and single read
    r0 = rd_cnt;
    exp_q.push_back(32'h1234_ABCD);
    start_frame("t1", 32'h1234_ABCD, t0);
    wait_write("t1_data", wc);
    check("t1_latency", 32'(wc - t0), 32'd3);
    step();
    check("t1_one_rd", 32'(rd_cnt - r0), 32'd1);
    check("t1_idle", 32'(busy), 32'd0);

    // T2 DAC backpressure with ADC still non-empty
    bus.dac_full = 1'b1;
    r0 = rd_cnt; w0 = wr_cnt;
    bus.adc_rdata = 32'hCAFE_0001;
    bus.adc_empty = 1'b0;
    repeat (14) step();
    check("t2_no_wr", 32'(wr_cnt - w0), 32'd0);
    check("t2_one_rd_held", 32'(rd_cnt - r0), 32'd1);
    check("t2_busy", 32'(busy), 32'd1);
    exp_q.push_back(32'hCAFE_0001);
    bus.dac_full = 1'b0;
    bus.adc_empty = 1'b1;
    wait_write("t2_data", wc);
    repeat (4) step();
    check("t2_one_write", 32'(wr_cnt - w0), 32'd1);
    check("t2_one_rd", 32'(rd_cnt - r0), 32'd1);

    // T3 effects chain round trip
    mode = 2'd1;
    exp_q.push_back(32'h0000_FFFF);
    start_frame("t3", 32'h1111_2222, t0);
    wait_tx("t3", s);
    check("t3_tx_data", bus.fx_tx_data, 32'h1111_2222);
    step(); step();
    check("t3_tx_hold_valid", 32'(bus.fx_tx_valid), 32'd1);
    check("t3_tx_hold_data", bus.fx_tx_data, 32'h1111_2222);
    bus.fx_tx_ready = 1'b1;
    step();
    bus.fx_tx_ready = 1'b0;
    check("t3_tx_dropped", 32'(bus.fx_tx_valid), 32'd0);
    repeat (3) step();
    bus.fx_rx_data = 32'h0000_FFFF;
    bus.fx_rx_valid = 1'b1;
    step();
    bus.fx_rx_valid = 1'b0;
    wait_write("t3_data", wc);
    check("t3_no_timeout", 32'(fx_timeout), 32'd0);

    // T4 effects timeout, err_clr colliding with the timeout, late reply, clear
    exp_q.push_back(32'hBEEF_0042);
    start_frame("t4", 32'hBEEF_0042, t0);
    wait_tx("t4", s);
    bus.fx_tx_ready = 1'b1;
    step();
    bus.fx_tx_ready = 1'b0;
    while (cyc < s + 16) step();
    check("t4_not_early", 32'(fx_timeout), 32'd0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("t4_set_wins", 32'(fx_timeout), 32'd1);
    wait_write("t4_data", wc);
    check("t4_write_cycle", 32'(wc - s), 32'd17);
    w0 = wr_cnt;
    repeat (2) step();
    bus.fx_rx_data = 32'h0BAD_0BAD;
    bus.fx_rx_valid = 1'b1;
    step();
    bus.fx_rx_valid = 1'b0;
    repeat (5) step();
    check("t4_late_ignored", 32'(wr_cnt - w0), 32'd0);
    check("t4_late_idle", 32'(busy), 32'd0);
    check("t4_sticky", 32'(fx_timeout), 32'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("t4_cleared", 32'(fx_timeout), 32'd0);

    // T5 peak metering over a 4-frame window
    mode = 2'd0;
    do_reset();
    p0 = pv_cnt;
    run_frame("t5_f0", 32'hFFFE_0064, 32'hFFFE_0064);
    run_frame("t5_f1", 32'h0003_8000, 32'h0003_8000);
    run_frame("t5_f2", 32'h012C_0005, 32'h012C_0005);
    check("t5_no_pv_yet", 32'(pv_cnt - p0), 32'd0);
    check("t5_peak_unchanged", peak, 32'd0);
    run_frame("t5_f3", 32'hFC18_0007, 32'hFC18_0007);
    check("t5_pv_once", 32'(pv_cnt - p0), 32'd1);
    check("t5_peak", peak, 32'h03E8_7FFF);
    run_frame("t5_f4", 32'h0000_0001, 32'h0000_0001);
    run_frame("t5_f5", 32'h0000_0002, 32'h0000_0002);
    run_frame("t5_f6", 32'h0000_0003, 32'h0000_0003);
    run_frame("t5_f7", 32'h0000_FFFC, 32'h0000_FFFC);
    check("t5_pv_twice", 32'(pv_cnt - p0), 32'd2);
    check("t5_peak_restart", peak, 32'h0000_0004);

    // T6 tone sawtooth, mid-frame mode change, mute, reset during WAIT_FX
    mode = 2'd3;
    exp_q.push_back(32'h0000_0000);
    start_frame("t6_f0", 32'h7777_7777, t0);
    mode = 2'd2;
    wait_write("t6_f0", wc);
    mode = 2'd3;
    run_frame("t6_f1", 32'h1234_5678, 32'h0040_0040);
    run_frame("t6_f2", 32'h1234_5678, 32'h0080_0080);
    mode = 2'd2;
    run_frame("t6_mute", 32'h5555_AAAA, 32'h0000_0000);
    mode = 2'd1;
    w0 = wr_cnt;
    start_frame("t6_fx", 32'h4242_4242, t0);
    wait_tx("t6", s);
    bus.fx_tx_ready = 1'b1;
    step();
    bus.fx_tx_ready = 1'b0;
    step();
    reset = 1'b1;
    bus.fx_rx_data = 32'hDEAD_BEEF;
    bus.fx_rx_valid = 1'b1;
    step();
    reset = 1'b0;
    bus.fx_rx_valid = 1'b0;
    repeat (3) step();
    check("t6_rst_idle", 32'(busy), 32'd0);
    check("t6_rst_no_write", 32'(wr_cnt - w0), 32'd0);
    check("t6_rst_no_timeout", 32'(fx_timeout), 32'd0);
    mode = 2'd3;
    run_frame("t6_after_rst", 32'h1234_5678, 32'h0000_0000);

    repeat (3) step();
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    check("no_stray_writes", 32'(obs_q.size() - obs_rd), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
